// File: rtl/dmem_if.sv
// Load-store port between the core's LoadStore stage and the data-memory slave.
// The request fields flow master->slave; the response and ready flow back.
interface dmem_if #(
    parameter int unsigned XLEN = 32
);
    logic            req;
    logic            write;
    logic [1:0]      n_bytes;
    logic            l_unsigned;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic            ready;
    logic            rvalid;
    logic [XLEN-1:0] rdata;
    logic            addr_err;

    modport master (
        output req, write, n_bytes, l_unsigned, addr, wdata,
        input  ready, rvalid, rdata, addr_err
    );

    modport slave (
        input  req, write, n_bytes, l_unsigned, addr, wdata,
        output ready, rvalid, rdata, addr_err
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Data-memory slave: word RAM with byte-enable stores, extended loads,
// address-error detection and a fixed number of wait states per request.
module dmem_ctrl #(
    parameter int unsigned     XLEN        = 32,
    parameter int unsigned     DEPTH_WORDS = 1024,
    parameter logic [XLEN-1:0] BASE_ADDR   = 32'h1000,
    parameter int unsigned     WAIT_STATES = 0
) (
    input  logic   clk,
    input  logic   rstn,
    dmem_if.slave  bus
);
    localparam int unsigned     IDXW  = $clog2(DEPTH_WORDS);
    localparam int unsigned     CNTW  = 4;
    localparam logic [XLEN-1:0] LIMIT = XLEN'(4 * DEPTH_WORDS);

    typedef struct packed {
        logic            write;
        logic [1:0]      n_bytes;
        logic            l_unsigned;
        logic [XLEN-1:0] addr;
        logic [XLEN-1:0] wdata;
    } req_t;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t          r_state, w_state_nxt;
    logic [CNTW-1:0] r_cnt, w_cnt_nxt;
    req_t            r_req, w_in, w_cur;
    logic            r_ready, r_rvalid, r_err;
    logic [XLEN-1:0] r_rdata;
    logic            w_ready_nxt, w_rvalid_nxt, w_err_nxt;
    logic [XLEN-1:0] w_rdata_nxt;
    logic            w_acc, w_fire, w_bad, w_we;
    logic [XLEN-1:0] w_off;
    logic [IDXW-1:0] w_idx;
    logic [1:0]      w_lane;
    logic [3:0]      w_be;
    logic [XLEN-1:0] w_wword, w_rword, w_load;
    logic [15:0]     w_shift;

    logic [XLEN-1:0] r_mem [DEPTH_WORDS];

    assign w_in  = {bus.write, bus.n_bytes, bus.l_unsigned, bus.addr, bus.wdata};
    assign w_acc = bus.req & r_ready;

    // Without wait states the access happens on the accept edge itself, so use the live request.
    assign w_cur = (WAIT_STATES == 0) ? w_in : r_req;

    assign w_off  = w_cur.addr - BASE_ADDR;
    assign w_idx  = w_off[IDXW+1:2];
    assign w_lane = w_cur.addr[1:0];

    // Size, alignment and range checks on the request being serviced.
    always_comb begin
        w_bad = 1'b0;
        case (w_cur.n_bytes)
            2'd0:    w_bad = 1'b0;
            2'd1:    w_bad = w_cur.addr[0];
            2'd2:    w_bad = |w_cur.addr[1:0];
            default: w_bad = 1'b1;
        endcase
        if ((w_cur.addr < BASE_ADDR) || (w_off >= LIMIT)) begin
            w_bad = 1'b1;
        end
    end

    // Byte enables and lane-replicated store data.
    always_comb begin
        w_be    = 4'b1111;
        w_wword = w_cur.wdata;
        case (w_cur.n_bytes)
            2'd0: begin
                w_be    = 4'b0001 << w_lane;
                w_wword = {4{w_cur.wdata[7:0]}};
            end
            2'd1: begin
                w_be    = 4'b0011 << w_lane;
                w_wword = {2{w_cur.wdata[15:0]}};
            end
            default: begin
                w_be    = 4'b1111;
                w_wword = w_cur.wdata;
            end
        endcase
    end

    // Lane extraction and sign/zero extension of load data.
    assign w_rword = r_mem[w_idx];
    assign w_shift = 16'(w_rword >> {w_lane, 3'b000});

    always_comb begin
        w_load = w_rword;
        case (w_cur.n_bytes)
            2'd0: w_load = w_cur.l_unsigned ? {{(XLEN-8){1'b0}}, w_shift[7:0]}
                                            : {{(XLEN-8){w_shift[7]}}, w_shift[7:0]};
            2'd1: w_load = w_cur.l_unsigned ? {{(XLEN-16){1'b0}}, w_shift}
                                            : {{(XLEN-16){w_shift[15]}}, w_shift};
            default: w_load = w_rword;
        endcase
    end

    // Next state, wait counter and registered response values.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE, S_RESP: begin
                if (w_acc) begin
                    if (WAIT_STATES > 0) begin
                        w_state_nxt = S_WAIT;
                        w_cnt_nxt   = CNTW'(WAIT_STATES - 1);
                    end else begin
                        w_state_nxt = S_RESP;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) begin
                    w_state_nxt = S_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - CNTW'(1);
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        w_fire       = (w_state_nxt == S_RESP);
        w_ready_nxt  = (w_state_nxt != S_WAIT);
        w_rvalid_nxt = w_fire;
        w_rdata_nxt  = r_rdata;
        w_err_nxt    = r_err;
        if (w_fire) begin
            w_err_nxt   = w_bad;
            w_rdata_nxt = (w_bad || w_cur.write) ? '0 : w_load;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_req    <= '0;
            r_ready  <= 1'b1;
            r_rvalid <= 1'b0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_ready  <= w_ready_nxt;
            r_rvalid <= w_rvalid_nxt;
            r_rdata  <= w_rdata_nxt;
            r_err    <= w_err_nxt;
            if (w_acc) begin
                r_req <= w_in;
            end
        end
    end

    // RAM write on the edge that enters RESP; blocked while reset is held.
    assign w_we = rstn & w_fire & w_cur.write & ~w_bad;

    always_ff @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (w_we && w_be[b]) begin
                r_mem[w_idx][8*b +: 8] <= w_wword[8*b +: 8];
            end
        end
    end

    assign bus.ready    = r_ready;
    assign bus.rvalid   = r_rvalid;
    assign bus.rdata    = r_rdata;
    assign bus.addr_err = r_err;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Directed bench for dmem_ctrl: one instance with no wait states, one with three.
module tb_dmem_ctrl;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    dmem_if #(.XLEN(32)) b0 ();
    dmem_if #(.XLEN(32)) b3 ();

    dmem_ctrl #(.XLEN(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h1000), .WAIT_STATES(0))
        u0 (.clk(clk), .rstn(rstn), .bus(b0));
    dmem_ctrl #(.XLEN(32), .DEPTH_WORDS(1024), .BASE_ADDR(32'h1000), .WAIT_STATES(3))
        u3 (.clk(clk), .rstn(rstn), .bus(b3));

    typedef struct packed {
        logic        w;
        logic [1:0]  nb;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
    } drv_t;

    typedef struct {
        logic        w;
        logic [1:0]  nb;
        logic        u;
        logic [31:0] a;
        logic [31:0] d;
        logic [31:0] exp;
        logic        eerr;
    } vec_t;

    drv_t        drv [2];
    logic        rq  [2];
    logic        rdy [2];
    logic        rv  [2];
    logic        er  [2];
    logic [31:0] rd  [2];

    assign b0.req = rq[0];       assign b3.req = rq[1];
    assign b0.write = drv[0].w;  assign b3.write = drv[1].w;
    assign b0.n_bytes = drv[0].nb; assign b3.n_bytes = drv[1].nb;
    assign b0.l_unsigned = drv[0].u; assign b3.l_unsigned = drv[1].u;
    assign b0.addr = drv[0].a;   assign b3.addr = drv[1].a;
    assign b0.wdata = drv[0].d;  assign b3.wdata = drv[1].d;
    assign rdy[0] = b0.ready;    assign rdy[1] = b3.ready;
    assign rv[0] = b0.rvalid;    assign rv[1] = b3.rvalid;
    assign er[0] = b0.addr_err;  assign er[1] = b3.addr_err;
    assign rd[0] = b0.rdata;     assign rd[1] = b3.rdata;

    int total = 0;
    int bad   = 0;
    vec_t tv [$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic w, input logic [1:0] nb, input logic u,
                                input logic [31:0] a, input logic [31:0] d,
                                input logic [31:0] exp, input logic eerr);
        vec_t v;
        v.w = w; v.nb = nb; v.u = u; v.a = a; v.d = d; v.exp = exp; v.eerr = eerr;
        return v;
    endfunction

    // One request on instance s; returns response and accept-to-rvalid latency in cycles.
    task automatic op(input int s, input logic w, input logic [1:0] nb, input logic u,
                      input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] o_rd, output logic o_err, output int lat);
        int n;
        drv[s] = '{w, nb, u, a, d};
        rq[s]  = 1'b1;
        n = 0;
        while (!rdy[s] && n < 40) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        rq[s] = 1'b0;
        lat = 1;
        while (!rv[s] && lat < 40) begin @(posedge clk); #1; lat++; end
        o_rd  = rd[s];
        o_err = er[s];
        @(posedge clk); #1;
        chk($sformatf("rvalid_pulse_i%0d", s), 32'(rv[s]), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        logic        e;
        int          lat;
        int          cnt;

        for (int s = 0; s < 2; s++) begin
            rq[s]  = 1'b0;
            drv[s] = '0;
        end

        // Reset values
        #12;
        for (int s = 0; s < 2; s++) begin
            chk($sformatf("rst_ready_i%0d", s),  32'(rdy[s]), 32'd1);
            chk($sformatf("rst_rvalid_i%0d", s), 32'(rv[s]),  32'd0);
            chk($sformatf("rst_rdata_i%0d", s),  rd[s],       32'd0);
            chk($sformatf("rst_err_i%0d", s),    32'(er[s]),  32'd0);
        end
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;

        // Directed vectors on the zero-wait instance
        tv.push_back(mk(1, 2, 0, 32'h1000, 32'hDEADBEEF, 32'h0,        0));
        tv.push_back(mk(0, 2, 0, 32'h1000, 32'h0,        32'hDEADBEEF, 0));
        tv.push_back(mk(1, 0, 0, 32'h1001, 32'h0000005A, 32'h0,        0));
        tv.push_back(mk(0, 0, 1, 32'h1001, 32'h0,        32'h0000005A, 0));
        tv.push_back(mk(0, 2, 0, 32'h1000, 32'h0,        32'hDEAD5AEF, 0));
        tv.push_back(mk(0, 0, 0, 32'h1003, 32'h0,        32'hFFFFFFDE, 0));
        tv.push_back(mk(0, 1, 1, 32'h1002, 32'h0,        32'h0000DEAD, 0));
        tv.push_back(mk(0, 2, 0, 32'h1002, 32'h0,        32'h0,        1));
        tv.push_back(mk(1, 1, 0, 32'h1001, 32'h0000FFFF, 32'h0,        1));
        tv.push_back(mk(0, 3, 0, 32'h1000, 32'h0,        32'h0,        1));
        tv.push_back(mk(1, 2, 0, 32'h0FFC, 32'h00000001, 32'h0,        1));
        tv.push_back(mk(1, 2, 0, 32'h2000, 32'h00000001, 32'h0,        1));
        tv.push_back(mk(0, 2, 0, 32'h1000, 32'h0,        32'hDEAD5AEF, 0));
        tv.push_back(mk(0, 1, 0, 32'h1000, 32'h0,        32'h00005AEF, 0));
        tv.push_back(mk(0, 0, 0, 32'h1000, 32'h0,        32'hFFFFFFEF, 0));
        tv.push_back(mk(1, 2, 0, 32'h1FFC, 32'h11223344, 32'h0,        0));
        tv.push_back(mk(1, 1, 0, 32'h1FFE, 32'hABCD8001, 32'h0,        0));
        tv.push_back(mk(0, 2, 0, 32'h1FFC, 32'h0,        32'h80013344, 0));
        tv.push_back(mk(0, 1, 0, 32'h1FFE, 32'h0,        32'hFFFF8001, 0));
        tv.push_back(mk(0, 0, 1, 32'h1FFD, 32'h0,        32'h00000033, 0));
        tv.push_back(mk(1, 0, 0, 32'h1002, 32'hFFFFFF77, 32'h0,        0));
        tv.push_back(mk(0, 2, 0, 32'h1000, 32'h0,        32'hDE775AEF, 0));

        @(posedge clk); #1;
        foreach (tv[i]) begin
            op(0, tv[i].w, tv[i].nb, tv[i].u, tv[i].a, tv[i].d, r, e, lat);
            chk($sformatf("vec%0d_rdata", i), r, tv[i].exp);
            chk($sformatf("vec%0d_err", i), 32'(e), 32'(tv[i].eerr));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd1);
        end

        // Back-to-back: 8 stores then 8 loads, a new request in every response cycle
        drv[0] = '{1'b1, 2'd2, 1'b0, 32'h1100, 32'h13570000};
        rq[0]  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b%0d_rvalid", i), 32'(rv[0]), 32'd1);
            chk($sformatf("b2b%0d_rdata", i), rd[0],
                (i < 8) ? 32'h0 : 32'h13570000 + 32'((i - 8) * 17));
            chk($sformatf("b2b%0d_err", i), 32'(er[0]), 32'd0);
            if (i < 7)
                drv[0] = '{1'b1, 2'd2, 1'b0, 32'h1100 + 32'(4 * (i + 1)),
                           32'h13570000 + 32'((i + 1) * 17)};
            else if (i < 15)
                drv[0] = '{1'b0, 2'd2, 1'b0, 32'h1100 + 32'(4 * (i - 7)), 32'h0};
            else
                rq[0] = 1'b0;
        end
        @(posedge clk); #1;
        chk("b2b_end_rvalid", 32'(rv[0]), 32'd0);

        // Three wait states: store, then a load with req held through the busy cycles
        op(1, 1, 2, 0, 32'h1000, 32'hCAFEF00D, r, e, lat);
        chk("ws3_sw_latency", 32'(lat), 32'd4);
        chk("ws3_sw_err", 32'(e), 32'd0);
        drv[1] = '{1'b0, 2'd2, 1'b0, 32'h1000, 32'h0};
        rq[1]  = 1'b1;
        @(posedge clk); #1;
        for (int k = 1; k <= 3; k++) begin
            chk($sformatf("ws3_busy%0d_ready", k), 32'(rdy[1]), 32'd0);
            chk($sformatf("ws3_busy%0d_rvalid", k), 32'(rv[1]), 32'd0);
            @(posedge clk); #1;
        end
        chk("ws3_lw_rvalid", 32'(rv[1]), 32'd1);
        chk("ws3_lw_ready", 32'(rdy[1]), 32'd1);
        chk("ws3_lw_rdata", rd[1], 32'hCAFEF00D);
        rq[1] = 1'b0;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (rv[1]) cnt++;
        end
        chk("ws3_no_double_accept", 32'(cnt), 32'd0);
        chk("ws3_rdata_hold", rd[1], 32'hCAFEF00D);

        op(1, 1, 2, 0, 32'h0FFC, 32'h1, r, e, lat);
        chk("ws3_err_flag", 32'(e), 32'd1);
        chk("ws3_err_latency", 32'(lat), 32'd4);
        op(1, 0, 2, 0, 32'h1000, 32'h0, r, e, lat);
        chk("ws3_lw2_rdata", r, 32'hCAFEF00D);

        // Reset pulse during WAIT of a store drops it
        drv[1] = '{1'b1, 2'd2, 1'b0, 32'h1000, 32'h12345678};
        rq[1]  = 1'b1;
        @(posedge clk); #1;
        rq[1] = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b0;
        #1;
        chk("rstmid_ready", 32'(rdy[1]), 32'd1);
        chk("rstmid_rvalid", 32'(rv[1]), 32'd0);
        chk("rstmid_rdata", rd[1], 32'd0);
        chk("rstmid_err", 32'(er[1]), 32'd0);
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        cnt = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clk); #1;
            if (rv[1]) cnt++;
        end
        chk("rstmid_no_rvalid", 32'(cnt), 32'd0);
        op(1, 0, 2, 0, 32'h1000, 32'h0, r, e, lat);
        chk("rstmid_old_data", r, 32'hCAFEF00D);
        chk("rstmid_lw_latency", 32'(lat), 32'd4);
        op(0, 0, 2, 0, 32'h1FFC, 32'h0, r, e, lat);
        chk("ram_kept_over_reset", r, 32'h80013344);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
